packed_array_serializer: RTL and testbench

Unpacks a captured two-dimensional packed array, `[N-1:0][W-1:0]`, into a stream of N single W-bit words. It is the stage directly downstream of the block that builds the packed row/column array. It takes a whole array in one valid/ready beat and emits the elements one per accepted beat. The default order is MSB element first (index N-1 down to 0), with an option for LSB-first order.

---
 rtl/packed_array_serializer_if.sv | 30 +++
 rtl/packed_array_serializer.sv | 70 +++++++
 tb/tb_packed_array_serializer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/packed_array_serializer_if.sv
// Handshake bundle for packed_array_serializer.
//   Upstream side : i_valid, i_data (whole [N-1:0][W-1:0] array), o_ready
//   Downstream side: o_valid, o_data, o_index, o_last, i_ready
//   Status        : o_busy (an array is held)
// slave modport is the serializer; master modport is whoever drives it.
interface packed_array_serializer_if #(
  parameter int N  = 10,
  parameter int W  = 20,
  parameter int IW = (N > 1) ? $clog2(N) : 1
);
  logic                  i_valid;
  logic                  o_ready;
  logic [N-1:0][W-1:0]   i_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [W-1:0]          o_data;
  logic [IW-1:0]         o_index;
  logic                  o_last;
  logic                  o_busy;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_index, o_last, o_busy
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_index, o_last, o_busy
  );
endinterface

// File: rtl/packed_array_serializer.sv
// packed_array_serializer
// Captures a packed [N-1:0][W-1:0] array in one valid/ready beat and emits
// its N elements one per accepted beat, MSB element first by default
// (LSB_FIRST=1 reverses the order).
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous active-high reset
//   bus    - packed_array_serializer_if.slave: i_valid/o_ready/i_data in,
//            o_valid/i_ready/o_data/o_index/o_last out, o_busy status
// All outputs come from registers; only o_ready also looks at i_ready, so a
// new array can be taken on the final beat of the current one.
module packed_array_serializer #(
  parameter  int N         = 10,
  parameter  int W         = 20,
  parameter  int LSB_FIRST = 0,
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  packed_array_serializer_if.slave      bus
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IW-1:0] TOP_IDX   = IW'(N - 1);
  localparam logic [IW-1:0] FIRST_IDX = (LSB_FIRST != 0) ? '0 : TOP_IDX;
  localparam logic [IW-1:0] LAST_IDX  = (LSB_FIRST != 0) ? TOP_IDX : '0;

  state_t               state_q;
  logic [N-1:0][W-1:0]  arr_q;
  logic [IW-1:0]        idx_q;

  logic sending, last, fire, cap;

  assign sending = (state_q == SEND);
  assign last    = sending && (idx_q == LAST_IDX);
  assign fire    = sending && bus.i_ready;
  // Ready on the final accepted beat too: that is what makes arrays
  // stream back-to-back without a bubble.
  assign bus.o_ready = (state_q == IDLE) || (fire && last);
  assign cap         = bus.i_valid && bus.o_ready;

  assign bus.o_valid = sending;
  assign bus.o_busy  = sending;
  assign bus.o_last  = last;
  assign bus.o_index = idx_q;
  assign bus.o_data  = arr_q[idx_q];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      arr_q   <= '0;
      idx_q   <= '0;
    end else if (cap) begin
      // Covers both the idle capture and the capture on a final beat.
      state_q <= SEND;
      arr_q   <= bus.i_data;
      idx_q   <= FIRST_IDX;
    end else if (fire) begin
      if (last) begin
        state_q <= IDLE;
      end else if (LSB_FIRST != 0) begin
        idx_q <= idx_q + 1'b1;
      end else begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_packed_array_serializer.sv
module tb_packed_array_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus for the MSB-first and LSB-first instances (same timing).
  logic                valid, rdy;
  logic [9:0][19:0]    data;
  // Stimulus for the N=1 instance.
  logic                v1, r1;
  logic [0:0][7:0]     d1;

  packed_array_serializer_if #(.N(10), .W(20)) bm ();
  packed_array_serializer_if #(.N(10), .W(20)) bl ();
  packed_array_serializer_if #(.N(1),  .W(8))  b1 ();

  assign bm.i_valid = valid;  assign bm.i_data = data;  assign bm.i_ready = rdy;
  assign bl.i_valid = valid;  assign bl.i_data = data;  assign bl.i_ready = rdy;
  assign b1.i_valid = v1;     assign b1.i_data = d1;    assign b1.i_ready = r1;

  packed_array_serializer #(.N(10), .W(20), .LSB_FIRST(0)) u_msb (.i_clk(clk), .i_rst(rst), .bus(bm));
  packed_array_serializer #(.N(10), .W(20), .LSB_FIRST(1)) u_lsb (.i_clk(clk), .i_rst(rst), .bus(bl));
  packed_array_serializer #(.N(1),  .W(8),  .LSB_FIRST(0)) u_one (.i_clk(clk), .i_rst(rst), .bus(b1));

  typedef struct {
    logic [19:0] d;
    int          idx;
    logic        last;
  } exp_t;

  exp_t qm[$], ql[$], q1[$];
  int checks = 0;
  int errors = 0;
  int acc_m  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [9:0][19:0] mk(input logic [19:0] b, input logic [19:0] s);
    logic [9:0][19:0] a;
    for (int k = 0; k < 10; k++) begin
      logic [19:0] kk;
      kk   = 20'(k);
      a[k] = b + kk * s;
    end
    return a;
  endfunction

  // Scoreboards: expected ready/busy from queue occupancy, push on capture,
  // pop and compare on every accepted output beat.
  always @(negedge clk) begin : mon_msb
    exp_t e;
    if (!rst) begin
      chk("msb_ready", 32'(bm.o_ready), 32'((qm.size() == 0) || (rdy && qm.size() == 1)));
      chk("msb_valid", 32'(bm.o_valid), 32'(qm.size() != 0));
      chk("msb_busy",  32'(bm.o_busy),  32'(qm.size() != 0));
      if (bm.o_valid && rdy) begin
        acc_m++;
        if (qm.size() == 0) fail("msb_unexpected_word");
        else begin
          e = qm.pop_front();
          chk("msb_data",  32'(bm.o_data),  32'(e.d));
          chk("msb_index", 32'(bm.o_index), 32'(e.idx));
          chk("msb_last",  32'(bm.o_last),  32'(e.last));
        end
      end
      if (valid && bm.o_ready)
        for (int k = 9; k >= 0; k--) qm.push_back('{data[k], k, k == 0});
    end
  end

  always @(negedge clk) begin : mon_lsb
    exp_t e;
    if (!rst) begin
      chk("lsb_ready", 32'(bl.o_ready), 32'((ql.size() == 0) || (rdy && ql.size() == 1)));
      chk("lsb_valid", 32'(bl.o_valid), 32'(ql.size() != 0));
      if (bl.o_valid && rdy) begin
        if (ql.size() == 0) fail("lsb_unexpected_word");
        else begin
          e = ql.pop_front();
          chk("lsb_data",  32'(bl.o_data),  32'(e.d));
          chk("lsb_index", 32'(bl.o_index), 32'(e.idx));
          chk("lsb_last",  32'(bl.o_last),  32'(e.last));
        end
      end
      if (valid && bl.o_ready)
        for (int k = 0; k < 10; k++) ql.push_back('{data[k], k, k == 9});
    end
  end

  always @(negedge clk) begin : mon_one
    exp_t e;
    if (!rst) begin
      chk("one_ready", 32'(b1.o_ready), 32'((q1.size() == 0) || (r1 && q1.size() == 1)));
      chk("one_valid", 32'(b1.o_valid), 32'(q1.size() != 0));
      if (b1.o_valid && r1) begin
        if (q1.size() == 0) fail("one_unexpected_word");
        else begin
          e = q1.pop_front();
          chk("one_data",  32'(b1.o_data),  32'(e.d));
          chk("one_index", 32'(b1.o_index), 32'(e.idx));
          chk("one_last",  32'(b1.o_last),  32'(e.last));
        end
      end
      if (v1 && b1.o_ready) q1.push_back('{20'(d1[0]), 0, 1'b1});
    end
  end

  task automatic send(input logic [9:0][19:0] a);
    int n;
    valid = 1'b1;
    data  = a;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bm.o_ready) break;
    end
    if (n == 200) fail("send_timeout");
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] a);
    int n;
    v1    = 1'b1;
    d1[0] = a;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (b1.o_ready) break;
    end
    if (n == 200) fail("send1_timeout");
    @(posedge clk); #1;
    v1 = 1'b0;
  endtask

  task automatic drain(input int pct);
    int n;
    @(posedge clk); #1;
    for (n = 0; n < 1000; n++) begin
      if (qm.size() == 0 && ql.size() == 0 && q1.size() == 0) break;
      rdy = ($urandom_range(99) < pct);
      r1  = ($urandom_range(99) < pct);
      @(posedge clk); #1;
    end
    if (n == 1000) fail("drain_timeout");
  endtask

  typedef struct {
    logic [19:0] base;
    logic [19:0] stride;
    int          pct;
    logic [19:0] exp_msb_first;
    logic [19:0] exp_lsb_first;
  } vec_t;

  vec_t tbl[4];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, acc0;
    tbl[0] = '{20'h00001, 20'h00001, 100, 20'h0000A, 20'h00001};
    tbl[1] = '{20'h00100, 20'h00010,  50, 20'h00190, 20'h00100};
    tbl[2] = '{20'hFFFFF, 20'hFFFFF,  70, 20'hFFFF6, 20'hFFFFF};
    tbl[3] = '{20'hAAAAA, 20'h00000,  30, 20'hAAAAA, 20'hAAAAA};

    rst = 1'b1; valid = 1'b0; rdy = 1'b0; data = '0;
    v1 = 1'b0; r1 = 1'b0; d1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bm.o_valid), 32'd0);
    chk("rst_ready", 32'(bm.o_ready), 32'd1);
    chk("rst_index", 32'(bm.o_index), 32'd0);
    chk("rst_data",  32'(bm.o_data),  32'd0);
    chk("rst_last",  32'(bm.o_last),  32'd0);
    chk("rst_busy",  32'(bm.o_busy),  32'd0);
    rst = 1'b0;

    // Table-driven arrays through both orderings.
    for (int i = 0; i < 4; i++) begin
      rdy = 1'b1;
      send(mk(tbl[i].base, tbl[i].stride));
      @(negedge clk);
      chk("tbl_msb_first", 32'(bm.o_data), 32'(tbl[i].exp_msb_first));
      chk("tbl_lsb_first", 32'(bl.o_data), 32'(tbl[i].exp_lsb_first));
      drain(tbl[i].pct);
    end

    // Back-pressure: random ready, then a 5-cycle stall on index 5.
    acc0 = acc_m;
    rdy  = 1'b0;
    send(mk(20'h1, 20'h1));
    for (n = 0; n < 200; n++) begin
      if (bm.o_valid && bm.o_index == 4'd5) break;
      rdy = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    if (n == 200) fail("stall_reach_idx5");
    rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(bm.o_valid), 32'd1);
      chk("stall_data",  32'(bm.o_data),  32'd6);
      chk("stall_index", 32'(bm.o_index), 32'd5);
      chk("stall_last",  32'(bm.o_last),  32'd0);
    end
    drain(50);
    chk("stall_words", 32'(acc_m - acc0), 32'd10);

    // Back-to-back arrays with no bubble.
    rdy = 1'b1;
    send(mk(20'hAAAAA, 20'h0));
    fork
      send(mk(20'h55555, 20'h0));
      repeat (20) begin
        @(negedge clk);
        chk("b2b_valid", 32'(bm.o_valid), 32'd1);
      end
    join
    drain(100);

    // Reset mid-stream, then a clean array.
    rdy = 1'b1;
    send(mk(20'h00500, 20'h1));
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    qm.delete(); ql.delete(); q1.delete();
    #1;
    chk("mid_rst_valid", 32'(bm.o_valid), 32'd0);
    chk("mid_rst_ready", 32'(bm.o_ready), 32'd1);
    chk("mid_rst_index", 32'(bm.o_index), 32'd0);
    chk("mid_rst_data",  32'(bm.o_data),  32'd0);
    chk("mid_rst_busy",  32'(bm.o_busy),  32'd0);
    chk("mid_rst_lsb_valid", 32'(bl.o_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(mk(20'h1, 20'h1));
    @(negedge clk);
    chk("post_rst_data",  32'(bm.o_data),  32'd10);
    chk("post_rst_index", 32'(bm.o_index), 32'd9);
    drain(100);

    // N=1: two single-element arrays back-to-back.
    r1 = 1'b1;
    send1(8'h3C);
    chk("one_first_data", 32'(b1.o_data), 32'h3C);
    chk("one_first_last", 32'(b1.o_last), 32'd1);
    send1(8'hC3);
    chk("one_second_data", 32'(b1.o_data), 32'hC3);
    chk("one_second_idx",  32'(b1.o_index), 32'd0);
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
